// File: rtl/qsp_seq_ctrl.sv
// rtl/qsp_seq_ctrl.sv - QSP scalar sequencer: PC, fetch, control-op execution and ALU issue gating
package qsp_seq_pkg;
    typedef enum logic [4:0] {
        OP_NOP       = 5'd0,
        OP_ADD_IMM   = 5'd1,
        OP_ADD_REG   = 5'd2,
        OP_SUB_IMM   = 5'd3,
        OP_SUB_REG   = 5'd4,
        OP_SHL_IMM   = 5'd5,
        OP_SHL_REG   = 5'd6,
        OP_SHR_IMM   = 5'd7,
        OP_SHR_REG   = 5'd8,
        OP_CMP_IMM   = 5'd9,
        OP_CMP_REG   = 5'd10,
        OP_MOV_IMM   = 5'd11,
        OP_MOV_REG   = 5'd12,
        OP_LCSET_IMM = 5'd13,
        OP_LCSET_REG = 5'd14,
        OP_LOOP      = 5'd15,
        OP_BRANCH    = 5'd16,
        OP_HALT      = 5'd17,
        OP_YIELD     = 5'd18
    } op_t;
endpackage

module qsp_seq_ctrl
    import qsp_seq_pkg::*;
#(
    parameter int                     PC_WIDTH   = 10,
    parameter int                     LC_WIDTH   = 18,
    parameter int                     DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [PC_WIDTH-1:0]   start_pc_i,
    input  logic                  resume_i,
    output logic                  imem_req_o,
    output logic [PC_WIDTH-1:0]   imem_addr_o,
    input  logic [31:0]           imem_rdata_i,
    output logic [31:0]           instr_o,
    input  op_t                   op_i,
    input  logic [DATA_WIDTH-1:0] imm_ext_i,
    input  logic                  illegal_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    output logic                  issue_o,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [LC_WIDTH-1:0]   loop_count_o,
    output logic                  busy_o,
    output logic                  halted_o,
    output logic                  yielded_o,
    output logic                  fault_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXEC    = 3'd2,
        S_HALTED  = 3'd3,
        S_YIELDED = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [LC_WIDTH-1:0] r_lc;

    logic                w_exec;
    logic                w_alu_op;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_pc_rel;
    logic                w_unused_imm;

    assign w_exec       = (r_state == S_EXEC);
    assign w_pc_inc     = r_pc + PC_WIDTH'(1);
    assign w_pc_rel     = r_pc + imm_ext_i[PC_WIDTH-1:0];
    assign w_unused_imm = ^imm_ext_i[DATA_WIDTH-1:LC_WIDTH];

    always_comb begin
        w_alu_op = 1'b0;
        case (op_i)
            OP_ADD_IMM, OP_ADD_REG, OP_SUB_IMM, OP_SUB_REG,
            OP_SHL_IMM, OP_SHL_REG, OP_SHR_IMM, OP_SHR_REG,
            OP_CMP_IMM, OP_CMP_REG, OP_MOV_IMM, OP_MOV_REG: w_alu_op = 1'b1;
            default:                                        w_alu_op = 1'b0;
        endcase
    end

    // Issue is purely a function of the EXEC state, so an async reset kills it instantly.
    assign issue_o      = w_exec && !illegal_i && w_alu_op;
    assign instr_o      = w_exec ? imem_rdata_i : 32'd0;
    assign imem_req_o   = (r_state == S_FETCH);
    assign imem_addr_o  = r_pc;
    assign pc_o         = r_pc;
    assign loop_count_o = r_lc;
    assign busy_o       = (r_state == S_FETCH) || w_exec;
    assign halted_o     = (r_state == S_HALTED);
    assign yielded_o    = (r_state == S_YIELDED);
    assign fault_o      = (r_state == S_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_lc    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED, S_FAULT: begin
                    if (start_i) begin
                        r_pc    <= start_pc_i;
                        r_lc    <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_EXEC;
                S_EXEC: begin
                    if (illegal_i) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_state <= S_FETCH;
                        r_pc    <= w_pc_inc;
                        case (op_i)
                            OP_LCSET_IMM: r_lc <= imm_ext_i[LC_WIDTH-1:0];
                            OP_LCSET_REG: r_lc <= rs1_data_i[LC_WIDTH-1:0];
                            OP_LOOP: begin
                                if (r_lc != '0) begin
                                    r_lc <= r_lc - LC_WIDTH'(1);
                                    r_pc <= w_pc_rel;
                                end
                            end
                            OP_BRANCH: begin
                                if (rs1_data_i != '0) r_pc <= w_pc_rel;
                            end
                            OP_HALT: begin
                                r_pc    <= r_pc;
                                r_state <= S_HALTED;
                            end
                            OP_YIELD: r_state <= S_YIELDED;
                            default: ;
                        endcase
                    end
                end
                S_YIELDED: begin
                    if (resume_i) r_state <= S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qsp_seq_ctrl.sv
// tb/tb_qsp_seq_ctrl.sv - scoreboard bench for qsp_seq_ctrl with behavioural imem and decoder
module tb_qsp_seq_ctrl;
    import qsp_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [9:0]  start_pc_i = '0;
    logic        resume_i = 1'b0;
    logic        imem_req_o;
    logic [9:0]  imem_addr_o;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] instr_o;
    op_t         op_i;
    logic [31:0] imm_ext_i;
    logic        illegal_i;
    logic [31:0] rs1_data_i = '0;
    logic        issue_o;
    logic [9:0]  pc_o;
    logic [17:0] loop_count_o;
    logic        busy_o, halted_o, yielded_o, fault_o;

    qsp_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .start_pc_i(start_pc_i),
        .resume_i(resume_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i), .instr_o(instr_o), .op_i(op_i),
        .imm_ext_i(imm_ext_i), .illegal_i(illegal_i), .rs1_data_i(rs1_data_i),
        .issue_o(issue_o), .pc_o(pc_o), .loop_count_o(loop_count_o),
        .busy_o(busy_o), .halted_o(halted_o), .yielded_o(yielded_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];

    always @(posedge clk) begin
        if (imem_req_o) imem_rdata_i <= mem[imem_addr_o];
    end

    assign op_i      = op_t'(instr_o[31:27]);
    assign imm_ext_i = {{16{instr_o[15]}}, instr_o[15:0]};
    assign illegal_i = instr_o[21];

    typedef struct {
        logic [9:0] pc;
        logic       iss;
    } exp_t;
    exp_t exp_q[$];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input op_t op, input int imm, input bit ill);
        logic [31:0] v;
        v = imm;
        return {op, 5'd0, ill, 5'd0, v[15:0]};
    endfunction

    task automatic push(input logic [9:0] pc, input logic iss);
        exp_t e;
        e.pc  = pc;
        e.iss = iss;
        exp_q.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    endtask

    // EXEC is the only busy cycle without a fetch strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            check("issue_gate", {31'd0, issue_o && !(busy_o && !imem_req_o)}, 32'd0);
            if (busy_o && !imem_req_o) begin
                if (exp_q.size() == 0) begin
                    check("exec_unexpected", {22'd0, pc_o}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("exec_pc", {22'd0, pc_o}, {22'd0, e.pc});
                    check("exec_issue", {31'd0, issue_o}, {31'd0, e.iss});
                end
            end
        end
    end

    task automatic pulse_start(input logic [9:0] pc);
        @(negedge clk);
        start_i    = 1'b1;
        start_pc_i = pc;
        @(negedge clk);
        start_i    = 1'b0;
    endtask

    task automatic pulse_resume();
        @(negedge clk);
        resume_i = 1'b1;
        @(negedge clk);
        resume_i = 1'b0;
    endtask

    task automatic wait_stop(input string tag);
        int n;
        n = 0;
        while (!(halted_o || yielded_o || fault_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, n < 200}, 32'd1);
        check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        clear_mem();
        #1;
        check("rst_pc", {22'd0, pc_o}, 32'd0);
        check("rst_flags", {26'd0, busy_o, halted_o, yielded_o, fault_o, issue_o, imem_req_o}, 32'd0);
        check("rst_lc", {14'd0, loop_count_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // straight-line program, exact halt latency
        mem[10'h010] = mk(OP_ADD_IMM, 4, 0);
        mem[10'h011] = mk(OP_NOP, 0, 0);
        mem[10'h012] = mk(OP_HALT, 0, 0);
        push(10'h010, 1); push(10'h011, 0); push(10'h012, 0);
        pulse_start(10'h010);
        repeat (5) @(negedge clk);
        check("t1_not_halted_early", {31'd0, halted_o}, 32'd0);
        @(negedge clk);
        check("t1_halted", {31'd0, halted_o}, 32'd1);
        check("t1_pc", {22'd0, pc_o}, 32'h012);
        check("t1_sb_empty", exp_q.size(), 32'd0);

        // LCSET 3 + LOOP -1: body runs 4 times
        clear_mem();
        mem[0] = mk(OP_LCSET_IMM, 3, 0);
        mem[1] = mk(OP_ADD_REG, 0, 0);
        mem[2] = mk(OP_LOOP, -1, 0);
        mem[3] = mk(OP_HALT, 0, 0);
        push(0, 0);
        for (int i = 0; i < 4; i++) begin
            push(1, 1);
            push(2, 0);
        end
        push(3, 0);
        pulse_start(10'h000);
        wait_stop("t2_stop");
        check("t2_halted", {31'd0, halted_o}, 32'd1);
        check("t2_pc", {22'd0, pc_o}, 32'h003);
        check("t2_lc", {14'd0, loop_count_o}, 32'd0);

        // BRANCH not taken / taken
        clear_mem();
        mem[10'h020] = mk(OP_BRANCH, 5, 0);
        mem[10'h021] = mk(OP_HALT, 0, 0);
        mem[10'h025] = mk(OP_HALT, 0, 0);
        rs1_data_i = 32'd0;
        push(10'h020, 0); push(10'h021, 0);
        pulse_start(10'h020);
        wait_stop("t3a_stop");
        check("t3a_pc", {22'd0, pc_o}, 32'h021);
        rs1_data_i = 32'd7;
        push(10'h020, 0); push(10'h025, 0);
        pulse_start(10'h020);
        wait_stop("t3b_stop");
        check("t3b_pc", {22'd0, pc_o}, 32'h025);

        // PC wraparound
        clear_mem();
        mem[10'h3FF] = mk(OP_BRANCH, 2, 0);
        mem[10'h001] = mk(OP_HALT, 0, 0);
        rs1_data_i = 32'd1;
        push(10'h3FF, 0); push(10'h001, 0);
        pulse_start(10'h3FF);
        wait_stop("t4a_stop");
        check("t4a_pc", {22'd0, pc_o}, 32'h001);
        mem[10'h3FF] = mk(OP_NOP, 0, 0);
        mem[10'h000] = mk(OP_HALT, 0, 0);
        push(10'h3FF, 0); push(10'h000, 0);
        pulse_start(10'h3FF);
        wait_stop("t4b_stop");
        check("t4b_pc", {22'd0, pc_o}, 32'h000);

        // illegal -> FAULT, resume ignored, start recovers; LCSET_REG truncation
        clear_mem();
        mem[10'h040] = mk(OP_ADD_IMM, 1, 1);
        push(10'h040, 0);
        pulse_start(10'h040);
        wait_stop("t5_stop");
        check("t5_fault", {31'd0, fault_o}, 32'd1);
        check("t5_pc", {22'd0, pc_o}, 32'h040);
        pulse_resume();
        @(negedge clk);
        check("t5_resume_ignored", {30'd0, fault_o, busy_o}, 32'b10);
        mem[0] = mk(OP_LCSET_REG, 0, 0);
        mem[1] = mk(OP_HALT, 0, 0);
        rs1_data_i = 32'h0005_0005;
        push(0, 0); push(1, 0);
        pulse_start(10'h000);
        check("t5_busy", {31'd0, busy_o}, 32'd1);
        wait_stop("t5b_stop");
        check("t5_lc_reg", {14'd0, loop_count_o}, 32'h10005);
        mem[0] = mk(OP_HALT, 0, 0);
        push(0, 0);
        pulse_start(10'h000);
        check("t5_lc_cleared", {14'd0, loop_count_o}, 32'd0);
        wait_stop("t5c_stop");

        // YIELD / resume, then reset during EXEC
        clear_mem();
        mem[10'h008] = mk(OP_YIELD, 0, 0);
        mem[10'h009] = mk(OP_ADD_IMM, 2, 0);
        mem[10'h00A] = mk(OP_HALT, 0, 0);
        push(10'h008, 0);
        pulse_start(10'h008);
        wait_stop("t6_stop");
        check("t6_yielded", {31'd0, yielded_o}, 32'd1);
        check("t6_pc", {22'd0, pc_o}, 32'h009);
        pulse_start(10'h030);
        @(negedge clk);
        check("t6_start_ignored", {21'd0, yielded_o, pc_o}, {21'd0, 1'b1, 10'h009});
        push(10'h009, 1); push(10'h00A, 0);
        pulse_resume();
        wait_stop("t6b_stop");
        check("t6_halt_pc", {22'd0, pc_o}, 32'h00A);

        mem[10'h050] = mk(OP_ADD_IMM, 1, 0);
        pulse_start(10'h050);
        @(posedge clk);
        #1;
        check("t6_in_exec_issue", {31'd0, issue_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_issue", {31'd0, issue_o}, 32'd0);
        check("t6_rst_pc", {22'd0, pc_o}, 32'd0);
        check("t6_rst_flags", {28'd0, busy_o, halted_o, yielded_o, fault_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_idle_after_rst", {21'd0, busy_o, pc_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule
